panel_ctrl: RTL and testbench

Parametrised front-panel controller for the board-emulation top level: synchronises and debounces the push button, classifies short and long presses, and drives N seven-segment digits and status LEDs from slide switches. It replaces the fixed one-shot priority-encoder display path with three selectable display modes. It has registered outputs and a press counter.

---
 rtl/panel_pkg.sv | 37 +++
 rtl/btn_press_detector.sv | 92 +++++++++
 rtl/hex_to_seven_seg.sv | 30 +++
 rtl/panel_ctrl.sv | 118 +++++++++++
 tb/tb_panel_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/panel_pkg.sv
// Shared types and constants for the front-panel controller.
// Display modes, press states and LED bit positions.
package panel_pkg;

  typedef enum logic [1:0] {
    MODE_ENC = 2'd0,
    MODE_CNT = 2'd1,
    MODE_RAW = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_LONG_HELD = 2'd2
  } press_state_e;

  localparam logic [6:0] SSEG_BLANK = 7'b0;

  localparam int LED_VALID   = 0;
  localparam int LED_MODE_LO = 1;
  localparam int LED_MODE_HI = 2;
  localparam int LED_BTN     = 3;

  // Code 3 is unreachable and behaves like ENC.
  function automatic logic [1:0] next_mode(
    input logic [1:0] m
  );
    logic [1:0] n;
    case (m)
      MODE_CNT: n = MODE_RAW;
      MODE_RAW: n = MODE_ENC;
      default:  n = MODE_CNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_press_detector.sv
// Button synchroniser, debouncer and short/long press classifier.
// Pulses are one cycle wide and at most one is produced per press.
module btn_press_detector
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_short_pulse,
  output logic o_long_pulse
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW  = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DBW-1:0] DB_MAX =
    DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX =
    HW'(LONG_PRESS_CYCLES - 1);

  logic [1:0]     r_sync;
  logic [DBW-1:0] r_db_cnt;
  logic           r_level;
  logic           r_level_d;
  logic [HW-1:0]  r_hold;
  press_state_e   r_state;

  logic w_rise;
  logic w_fall;

  assign w_rise = r_level & ~r_level_d;
  assign w_fall = ~r_level & r_level_d;

  assign o_level = r_level;
  assign o_short_pulse =
    (r_state == ST_HELD) & w_fall;
  assign o_long_pulse =
    (r_state == ST_HELD) & ~w_fall &
    (r_hold == HOLD_MAX);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync    <= '0;
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_hold    <= '0;
      r_state   <= ST_IDLE;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_d <= r_level;

      if (r_sync[1] == r_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_MAX) begin
        r_level  <= ~r_level;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end

      // Hold counter stops at HOLD_MAX, so it never wraps.
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_HELD;
            r_hold  <= '0;
          end
        end
        ST_HELD: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
          end else if (r_hold == HOLD_MAX) begin
            r_state <= ST_LONG_HELD;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hex_to_seven_seg.sv
// Hex nibble to active-high seven-segment pattern.
// Bit order is {g,f,e,d,c,b,a}.
module hex_to_seven_seg (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    case (i_hex)
      4'h0: o_seg = 7'h3F;
      4'h1: o_seg = 7'h06;
      4'h2: o_seg = 7'h5B;
      4'h3: o_seg = 7'h4F;
      4'h4: o_seg = 7'h66;
      4'h5: o_seg = 7'h6D;
      4'h6: o_seg = 7'h7D;
      4'h7: o_seg = 7'h07;
      4'h8: o_seg = 7'h7F;
      4'h9: o_seg = 7'h6F;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h7C;
      4'hC: o_seg = 7'h39;
      4'hD: o_seg = 7'h5E;
      4'hE: o_seg = 7'h79;
      default: o_seg = 7'h71;
    endcase
  end

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel controller: button modes, press counter and
// multi-digit seven-segment display driven from slide switches.
module panel_ctrl
  import panel_pkg::*;
#(
  parameter int N_SLIDE_SWITCHES  = 8,
  parameter int N_DIGITS          = 2,
  parameter int N_LEDS            = 4,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_btn,
  input  logic [N_SLIDE_SWITCHES-1:0] i_slide_switches,
  output logic [7*N_DIGITS-1:0]       o_sseg,
  output logic [N_LEDS-1:0]           o_leds
);

  localparam int DW = 4 * N_DIGITS;

  logic [N_SLIDE_SWITCHES-1:0] r_sw_s1;
  logic [N_SLIDE_SWITCHES-1:0] r_sw_s2;
  logic [1:0]                  r_mode;
  logic [DW-1:0]               r_cnt;
  logic [7*N_DIGITS-1:0]       r_sseg;
  logic                        r_enc_valid;

  logic                  w_level;
  logic                  w_short;
  logic                  w_long;
  logic [DW-1:0]         w_enc_idx;
  logic                  w_enc_valid;
  logic                  w_is_enc;
  logic [DW-1:0]         w_disp;
  logic [7*N_DIGITS-1:0] w_seg;
  logic [N_LEDS-1:0]     w_leds;

  btn_press_detector #(
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
  ) u_btn (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_btn         (i_btn),
    .o_level       (w_level),
    .o_short_pulse (w_short),
    .o_long_pulse  (w_long)
  );

  always_comb begin
    w_enc_idx = '0;
    for (int i = 0; i < N_SLIDE_SWITCHES; i++) begin
      if (r_sw_s2[i]) begin
        w_enc_idx = DW'(i);
      end
    end
  end

  assign w_enc_valid = |r_sw_s2;
  assign w_is_enc = (r_mode != MODE_CNT) &&
                    (r_mode != MODE_RAW);

  always_comb begin
    w_disp = w_enc_idx;
    case (r_mode)
      MODE_CNT: w_disp = r_cnt;
      MODE_RAW: w_disp = DW'(r_sw_s2);
      default:  w_disp = w_enc_idx;
    endcase
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
    hex_to_seven_seg u_hex (
      .i_hex (w_disp[4*k +: 4]),
      .o_seg (w_seg[7*k +: 7])
    );
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sw_s1     <= '0;
      r_sw_s2     <= '0;
      r_mode      <= MODE_ENC;
      r_cnt       <= '0;
      r_sseg      <= '0;
      r_enc_valid <= 1'b0;
    end else begin
      r_sw_s1 <= i_slide_switches;
      r_sw_s2 <= r_sw_s1;
      if (w_long) begin
        r_mode <= next_mode(r_mode);
      end
      if (w_short && (r_mode == MODE_CNT)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_is_enc && !w_enc_valid) begin
        r_sseg <= {N_DIGITS{SSEG_BLANK}};
      end else begin
        r_sseg <= w_seg;
      end
      r_enc_valid <= w_is_enc & w_enc_valid;
    end
  end

  // Mode and level bits are already flops; only valid needs its own.
  always_comb begin
    w_leds = '0;
    w_leds[LED_VALID]   = r_enc_valid;
    w_leds[LED_MODE_LO] = r_mode[0];
    w_leds[LED_MODE_HI] = r_mode[1];
    w_leds[LED_BTN]     = w_level;
  end

  assign o_sseg = r_sseg;
  assign o_leds = w_leds;

endmodule

// File: tb/tb_panel_ctrl.sv
// Directed bench for panel_ctrl with short debounce/long-press times.
// Each scenario task drives stimulus and checks inline.
module tb_panel_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn = 1'b0;
  logic [7:0]  sw = 8'h00;
  logic [13:0] sseg;
  logic [3:0]  leds;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] H0 = 7'h3F;
  localparam logic [6:0] H1 = 7'h06;
  localparam logic [6:0] H5 = 7'h6D;
  localparam logic [6:0] H7 = 7'h07;
  localparam logic [6:0] HA = 7'h77;
  localparam logic [6:0] HF = 7'h71;

  always #5 clk = ~clk;

  panel_ctrl #(
    .N_SLIDE_SWITCHES  (8),
    .N_DIGITS          (2),
    .N_LEDS            (4),
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (32)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_btn            (btn),
    .i_slide_switches (sw),
    .o_sseg           (sseg),
    .o_leds           (leds)
  );

  task automatic hold_btn(input int n);
    @(negedge clk);
    btn = 1'b1;
    repeat (n) @(negedge clk);
    btn = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset;
    sw = 8'h01;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (sseg !== {H0, H0}) begin
      n_fail++;
      $display("FAIL reset_pre_sseg: got %h want %h",
               sseg, {H0, H0});
    end
    n_checks++;
    if (leds !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_pre_leds: got %b want 0001", leds);
    end
    @(negedge clk);
    btn = 1'b1;
    repeat (25) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sseg !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_async_sseg: got %h want 0", sseg);
    end
    n_checks++;
    if (leds !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async_leds: got %b want 0000", leds);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (leds[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_redebounce: level %b want 0",
               leds[3]);
    end
    repeat (17) @(negedge clk);
    n_checks++;
    if (leds !== 4'b1001) begin
      n_fail++;
      $display("FAIL reset_fresh_press: got %b want 1001",
               leds);
    end
    btn = 1'b0;
    repeat (14) @(negedge clk);
    n_checks++;
    if (leds !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 0001", leds);
    end
  endtask

  task automatic test_enc;
    @(negedge clk);
    sw = 8'b0010_0110;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (sseg !== {H0, H0}) begin
      n_fail++;
      $display("FAIL enc_latency: got %h want %h",
               sseg, {H0, H0});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (sseg !== {H0, H5}) begin
      n_fail++;
      $display("FAIL enc_sseg: got %h want %h",
               sseg, {H0, H5});
    end
    n_checks++;
    if (leds !== 4'b0001) begin
      n_fail++;
      $display("FAIL enc_leds: got %b want 0001", leds);
    end
    @(negedge clk);
    sw = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sseg !== 14'h0) begin
      n_fail++;
      $display("FAIL enc_blank: got %h want 0", sseg);
    end
    n_checks++;
    if (leds !== 4'b0000) begin
      n_fail++;
      $display("FAIL enc_invalid: got %b want 0000", leds);
    end
  endtask

  task automatic test_long_press;
    @(negedge clk);
    btn = 1'b1;
    repeat (38) @(posedge clk);
    #1;
    n_checks++;
    if (leds[2:1] !== 2'b00) begin
      n_fail++;
      $display("FAIL long_early: mode %b want 00", leds[2:1]);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (leds[2:1] !== 2'b01) begin
      n_fail++;
      $display("FAIL long_mode: mode %b want 01", leds[2:1]);
    end
    @(negedge clk);
    @(negedge clk);
    btn = 1'b0;
    repeat (14) @(negedge clk);
    n_checks++;
    if (leds !== 4'b0010) begin
      n_fail++;
      $display("FAIL long_release_leds: got %b want 0010",
               leds);
    end
    n_checks++;
    if (sseg !== {H0, H0}) begin
      n_fail++;
      $display("FAIL long_no_incr: got %h want %h",
               sseg, {H0, H0});
    end
  endtask

  task automatic test_glitch;
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (leds[3] !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_level: level rose, want 0");
    end
    n_checks++;
    if (leds !== 4'b0010) begin
      n_fail++;
      $display("FAIL glitch_leds: got %b want 0010", leds);
    end
    n_checks++;
    if (sseg !== {H0, H0}) begin
      n_fail++;
      $display("FAIL glitch_cnt: got %h want %h",
               sseg, {H0, H0});
    end
  endtask

  task automatic test_counter_wrap;
    for (int i = 1; i <= 257; i++) begin
      hold_btn(10);
      if (i == 1) begin
        n_checks++;
        if (sseg !== {H0, H1}) begin
          n_fail++;
          $display("FAIL cnt_first: got %h want %h",
                   sseg, {H0, H1});
        end
      end
      if (i == 255) begin
        n_checks++;
        if (sseg !== {HF, HF}) begin
          n_fail++;
          $display("FAIL cnt_ff: got %h want %h",
                   sseg, {HF, HF});
        end
      end
      if (i == 256) begin
        n_checks++;
        if (sseg !== {H0, H0}) begin
          n_fail++;
          $display("FAIL cnt_wrap: got %h want %h",
                   sseg, {H0, H0});
        end
      end
    end
    n_checks++;
    if (sseg !== {H0, H1}) begin
      n_fail++;
      $display("FAIL cnt_257: got %h want %h",
               sseg, {H0, H1});
    end
    n_checks++;
    if (leds !== 4'b0010) begin
      n_fail++;
      $display("FAIL cnt_leds: got %b want 0010", leds);
    end
  endtask

  task automatic test_raw;
    hold_btn(40);
    n_checks++;
    if (leds[2:1] !== 2'b10) begin
      n_fail++;
      $display("FAIL raw_mode: mode %b want 10", leds[2:1]);
    end
    @(negedge clk);
    sw = 8'hA7;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sseg !== {HA, H7}) begin
      n_fail++;
      $display("FAIL raw_sseg: got %h want %h",
               sseg, {HA, H7});
    end
    n_checks++;
    if (leds !== 4'b0100) begin
      n_fail++;
      $display("FAIL raw_leds: got %b want 0100", leds);
    end
    hold_btn(40);
    n_checks++;
    if (leds !== 4'b0001) begin
      n_fail++;
      $display("FAIL raw_to_enc_leds: got %b want 0001",
               leds);
    end
    n_checks++;
    if (sseg !== {H0, H7}) begin
      n_fail++;
      $display("FAIL raw_to_enc_sseg: got %h want %h",
               sseg, {H0, H7});
    end
    hold_btn(40);
    n_checks++;
    if (sseg !== {H0, H1}) begin
      n_fail++;
      $display("FAIL cnt_held: got %h want %h",
               sseg, {H0, H1});
    end
    n_checks++;
    if (leds !== 4'b0010) begin
      n_fail++;
      $display("FAIL cnt_back_leds: got %b want 0010", leds);
    end
  endtask

  initial begin
    test_reset();
    test_enc();
    test_long_press();
    test_glitch();
    test_counter_wrap();
    test_raw();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
